// File: rtl/snake_pkg.sv
// Shared constants and clear-FSM state type for the snake tile RAM arbiter.
// Pure declarations; no latency and no flow control.
package snake_pkg;
    localparam int          NUM_TILES  = 4800;
    localparam int          ADDR_W     = 13;
    localparam int          DATA_W     = 8;
    localparam logic [7:0]  CLR_COLOUR = 8'h00;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } clr_state_t;
endpackage

// File: rtl/snake_tile_arbiter_if.sv
// Request/grant and RAM-port bundle between the game/VGA side and the tile arbiter.
// Wires only; timing is set by the arbiter (grants combinational, VVALID one cycle after VREQ).
interface snake_tile_arbiter_if;
    logic                          vreq;
    logic [snake_pkg::ADDR_W-1:0]  vaddr;
    logic [snake_pkg::DATA_W-1:0]  vdata;
    logic                          vvalid;
    logic                          wreq;
    logic [snake_pkg::ADDR_W-1:0]  waddr;
    logic [snake_pkg::DATA_W-1:0]  wdata;
    logic                          wgnt;
    logic                          clear_start;
    logic                          clear_busy;
    logic                          clear_done;
    logic [snake_pkg::ADDR_W-1:0]  ram_addr;
    logic                          ram_we;
    logic [snake_pkg::DATA_W-1:0]  ram_wdata;
    logic [snake_pkg::DATA_W-1:0]  ram_rdata;

    modport master (
        output vreq, vaddr, wreq, waddr, wdata, clear_start, ram_rdata,
        input  vdata, vvalid, wgnt, clear_busy, clear_done, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  vreq, vaddr, wreq, waddr, wdata, clear_start, ram_rdata,
        output vdata, vvalid, wgnt, clear_busy, clear_done, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/tile_clear_sequencer.sv
// Clear engine: walks every tile address once, requesting a write per address.
// One address per granted cycle; stalls on the current address while gnt is low.
module tile_clear_sequencer
    import snake_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              gnt,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done
);
    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                req  = 1'b1;
                busy = 1'b1;
                // Terminate on an explicit compare; the counter never wraps.
                if (gnt) begin
                    if (cnt == LAST_ADDR) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign addr = cnt;
endmodule

// File: rtl/snake_tile_arbiter.sv
// Shares the single tile RAM port: VGA reads first, then round-robin game writer vs clear engine.
// Grants are same-cycle combinational; VVALID follows VREQ by one cycle; writers stall during VREQ.
module snake_tile_arbiter
    import snake_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    snake_tile_arbiter_if.slave  bus
);
    logic              clr_req, clr_gnt, clr_busy, clr_done;
    logic [ADDR_W-1:0] clr_addr;
    logic              game_gnt;
    logic              rr_ptr;
    logic              vvalid_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;

    tile_clear_sequencer u_clear (
        .CLK   (CLK),
        .RESET (RESET),
        .start (bus.clear_start),
        .gnt   (clr_gnt),
        .req   (clr_req),
        .addr  (clr_addr),
        .busy  (clr_busy),
        .done  (clr_done)
    );

    // rr_ptr=1 means the game writer was served last, so the clear engine wins a tie.
    always_comb begin
        game_gnt  = 1'b0;
        clr_gnt   = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (bus.vreq) begin
            ram_addr = bus.vaddr;
        end else if (bus.wreq && (!clr_req || !rr_ptr)) begin
            game_gnt  = 1'b1;
            ram_we    = (bus.waddr <= LAST_ADDR);
            ram_addr  = bus.waddr;
            ram_wdata = bus.wdata;
        end else if (clr_req) begin
            clr_gnt   = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = CLR_COLOUR;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rr_ptr   <= 1'b0;
            vvalid_q <= 1'b0;
        end else begin
            vvalid_q <= bus.vreq;
            if (game_gnt)
                rr_ptr <= 1'b1;
            else if (clr_gnt)
                rr_ptr <= 1'b0;
        end
    end

    assign bus.vdata      = bus.ram_rdata;
    assign bus.vvalid     = vvalid_q;
    assign bus.wgnt       = game_gnt;
    assign bus.clear_busy = clr_busy;
    assign bus.clear_done = clr_done;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_we     = ram_we;
    assign bus.ram_wdata  = ram_wdata;
endmodule
